// File: rtl/tt_readout_pkg.sv
// Shared definitions for the SFQ readout blocks.
//   state_e   : windowed-counter FSM states
//   cnt_t     : pulse count at the default width
//   params_ok : parameter range check used at elaboration
package tt_readout_pkg;

  localparam int CNT_W_DEF = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_e;

  typedef logic [CNT_W_DEF-1:0] cnt_t;

  function automatic bit params_ok(int sync_stages, int cnt_w, int window, int min_gap);
    return (sync_stages >= 2) && (cnt_w >= 1) && (window >= 4) && (min_gap >= 1);
  endfunction

endpackage

// File: rtl/tt_skid_buf2.sv
// Two-entry FIFO-ordered valid/ready output buffer.
//   push/push_data        : write side, no backpressure (push into full drops)
//   out_data/out_valid/out_ready : read side handshake
//   full                  : both entries occupied
//   drop                  : this cycle's push was discarded
module tt_skid_buf2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         full,
  output logic         drop
);

  logic [1:0][W-1:0] mem_q, mem_d;
  logic              wr_q, wr_d;
  logic              rd_q, rd_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              pop, accept;

  assign out_valid = (cnt_q != 2'd0);
  assign full      = (cnt_q == 2'd2);
  assign out_data  = mem_q[rd_q];
  assign pop       = out_valid && out_ready;
  // A pop in the same cycle frees a slot, so a full buffer still accepts.
  assign accept    = push && (!full || pop);
  assign drop      = push && full && !pop;

  always_comb begin
    mem_d = mem_q;
    if (accept) mem_d[wr_q] = push_data;
    wr_d  = wr_q ^ accept;
    rd_d  = rd_q ^ pop;
    cnt_d = cnt_q + 2'(accept) - 2'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '0;
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tt_pulse_counter.sv
// Windowed pulse counter for a transition-coded (toggle) SFQ line.
//   tt_in             : toggle line, asynchronous to clk
//   enable            : start/continue windowed counting
//   cnt_data/valid/ready : one count per window, 2-entry buffered
//   gap_err/sat_err/drop_err : sticky error flags, cleared by rst only
module tt_pulse_counter import tt_readout_pkg::*; #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int WINDOW      = 64,
  parameter int MIN_GAP     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tt_in,
  input  logic             enable,
  output logic [CNT_W-1:0] cnt_data,
  output logic             cnt_valid,
  input  logic             cnt_ready,
  output logic             gap_err,
  output logic             sat_err,
  output logic             drop_err
);

  if (!params_ok(SYNC_STAGES, CNT_W, WINDOW, MIN_GAP)) begin : g_param_err
    $error("tt_pulse_counter: parameter out of range");
  end

  localparam int TMR_W  = $clog2(WINDOW);
  localparam int GAP_W  = $clog2(MIN_GAP + 1);
  localparam int FILL_W = $clog2(SYNC_STAGES + 2);

  localparam logic [TMR_W-1:0]  WIN_LAST = TMR_W'(WINDOW - 1);
  localparam logic [GAP_W-1:0]  GAP_MAX  = GAP_W'(MIN_GAP);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic [FILL_W-1:0]      fill_q, fill_d;
  logic [GAP_W-1:0]       gap_q, gap_d;
  state_e                 state_q, state_d;
  logic [TMR_W-1:0]       timer_q, timer_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
  logic                   gap_err_q, gap_err_d;
  logic                   sat_err_q, sat_err_d;
  logic                   drop_err_q, drop_err_d;
  logic                   armed, pulse, sat_hit, push;
  logic                   buf_full, buf_drop;
  logic                   unused_full;

  // Edge detection stays off until the history flop holds a real sample
  // that came through the whole synchroniser, so a line already high at
  // reset release is not seen as a transition.
  assign armed = (fill_q == FILL_MAX);
  assign pulse = armed && (sync_q[SYNC_STAGES-1] ^ hist_q);

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], tt_in};
    hist_d = sync_q[SYNC_STAGES-1];
    fill_d = armed ? fill_q : fill_q + FILL_W'(1);

    // Cycles since last pulse; a pulse restarts at 1 so that with
    // MIN_GAP=1 back-to-back pulses are legal.
    gap_err_d = gap_err_q;
    if (pulse) begin
      if (gap_q < GAP_MAX) gap_err_d = 1'b1;
      gap_d = GAP_W'(1);
    end else begin
      gap_d = (gap_q == GAP_MAX) ? gap_q : gap_q + GAP_W'(1);
    end

    sat_hit = 1'b0;
    cnt_inc = cnt_q;
    if (pulse) begin
      if (cnt_q == CNT_MAX) sat_hit = 1'b1;
      else                  cnt_inc = cnt_q + CNT_W'(1);
    end

    state_d   = state_q;
    timer_d   = timer_q;
    cnt_d     = cnt_q;
    sat_err_d = sat_err_q;
    push      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        cnt_d   = '0;
        if (enable) state_d = ST_COUNT;
      end
      ST_COUNT: begin
        if (sat_hit) sat_err_d = 1'b1;
        if (timer_q == WIN_LAST) begin
          // Final cycle: push the count including this cycle's pulse.
          push    = 1'b1;
          timer_d = '0;
          cnt_d   = '0;
          if (!enable) state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
          cnt_d   = cnt_inc;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    drop_err_d = drop_err_q | buf_drop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= '0;
      hist_q     <= 1'b0;
      fill_q     <= '0;
      gap_q      <= GAP_MAX;
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      cnt_q      <= '0;
      gap_err_q  <= 1'b0;
      sat_err_q  <= 1'b0;
      drop_err_q <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      hist_q     <= hist_d;
      fill_q     <= fill_d;
      gap_q      <= gap_d;
      state_q    <= state_d;
      timer_q    <= timer_d;
      cnt_q      <= cnt_d;
      gap_err_q  <= gap_err_d;
      sat_err_q  <= sat_err_d;
      drop_err_q <= drop_err_d;
    end
  end

  tt_skid_buf2 #(.W(CNT_W)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (cnt_inc),
    .out_data  (cnt_data),
    .out_valid (cnt_valid),
    .out_ready (cnt_ready),
    .full      (buf_full),
    .drop      (buf_drop)
  );

  assign unused_full = buf_full;

  assign gap_err  = gap_err_q;
  assign sat_err  = sat_err_q;
  assign drop_err = drop_err_q;

endmodule

// File: tb/tb_tt_pulse_counter.sv
module tb_tt_pulse_counter;

  logic       clk = 1'b0;
  logic       rst, tt_in, enable, cnt_ready, rdy4;
  logic [7:0] cnt_data;
  logic       cnt_valid, gap_err, sat_err, drop_err;
  logic [3:0] cnt_data4;
  logic       cnt_valid4, gap_err4, sat_err4, drop_err4;

  always #5 clk = ~clk;

  tt_pulse_counter u_dut (
    .clk(clk), .rst(rst), .tt_in(tt_in), .enable(enable),
    .cnt_data(cnt_data), .cnt_valid(cnt_valid), .cnt_ready(cnt_ready),
    .gap_err(gap_err), .sat_err(sat_err), .drop_err(drop_err)
  );

  // Narrow-counter copy sharing the same line, for saturation.
  tt_pulse_counter #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .tt_in(tt_in), .enable(enable),
    .cnt_data(cnt_data4), .cnt_valid(cnt_valid4), .cnt_ready(rdy4),
    .gap_err(gap_err4), .sat_err(sat_err4), .drop_err(drop_err4)
  );

  int n_cmp = 0;
  int n_err = 0;
  int q[$];
  int q4[$];

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Scoreboard: every accepted output is matched against the queue.
  always @(negedge clk) begin
    if (!rst && cnt_valid && cnt_ready) begin
      if (q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_result: got %0d, expected none", cnt_data);
      end else chk("cnt_data", int'(cnt_data), q.pop_front());
    end
    if (!rst && cnt_valid4 && rdy4) begin
      if (q4.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_result4: got %0d, expected none", cnt_data4);
      end else chk("cnt_data4", int'(cnt_data4), q4.pop_front());
    end
  end

  task automatic do_reset(input logic lvl);
    rst = 1'b1; enable = 1'b0; tt_in = lvl; cnt_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_drain(string nm);
    int i = 0;
    while ((q.size() != 0 || q4.size() != 0) && i < 300) begin
      @(negedge clk); i++;
    end
    if (q.size() != 0 || q4.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL %s_timeout: %0d results pending, expected 0", nm, q.size() + q4.size());
      q.delete(); q4.delete();
    end
  endtask

  typedef struct {
    int ntog; int gap; int exp_cnt; int exp_cnt4; bit exp_gap; bit exp_sat4;
  } vec_t;
  vec_t vecs[6];

  initial begin
    int tog[$];
    vecs[0] = '{5,  4, 5,  5,  1'b0, 1'b0};
    vecs[1] = '{0,  4, 0,  0,  1'b0, 1'b0};
    vecs[2] = '{2,  1, 2,  2,  1'b1, 1'b0};
    vecs[3] = '{20, 3, 20, 15, 1'b0, 1'b1};
    vecs[4] = '{25, 2, 25, 15, 1'b0, 1'b1};
    vecs[5] = '{12, 2, 12, 12, 1'b0, 1'b0};
    rdy4 = 1'b1;

    // Reset state
    do_reset(1'b0);
    chk("rst_valid", cnt_valid, 0);
    chk("rst_data", cnt_data, 0);
    chk("rst_gap", gap_err, 0);
    chk("rst_sat", sat_err, 0);
    chk("rst_drop", drop_err, 0);

    // Single window per vector; enable drops mid-window after the toggles.
    foreach (vecs[v]) begin
      do_reset(1'b0);
      @(negedge clk); enable = 1'b1;
      repeat (2) @(negedge clk);
      for (int k = 0; k < vecs[v].ntog; k++) begin
        tt_in = ~tt_in;
        repeat (vecs[v].gap) @(negedge clk);
      end
      enable = 1'b0;
      q.push_back(vecs[v].exp_cnt);
      q4.push_back(vecs[v].exp_cnt4);
      wait_drain("vec");
      repeat (80) @(negedge clk);
      chk("vec_gap", gap_err, vecs[v].exp_gap);
      chk("vec_sat", sat_err, 0);
      chk("vec_drop", drop_err, 0);
      chk("vec_gap4", gap_err4, vecs[v].exp_gap);
      chk("vec_sat4", sat_err4, vecs[v].exp_sat4);
      chk("vec_idle", cnt_valid, 0);
    end

    // Line high through reset, no toggles: two zero windows.
    do_reset(1'b1);
    q.push_back(0); q.push_back(0); q4.push_back(0); q4.push_back(0);
    @(negedge clk); enable = 1'b1;
    repeat (100) @(negedge clk);
    enable = 1'b0;
    wait_drain("high");
    repeat (80) @(negedge clk);
    chk("high_gap", gap_err, 0);
    chk("high_valid", cnt_valid, 0);

    // enable drops at cycle 10; window still completes, result latency exact.
    do_reset(1'b0);
    q.push_back(4); q4.push_back(4);
    @(negedge clk); enable = 1'b1;
    for (int o = 1; o <= 140; o++) begin
      @(negedge clk);
      if (o == 2 || o == 6 || o == 10 || o == 14) tt_in = ~tt_in;
      if (o == 10) enable = 1'b0;
      if (o == 64) chk("valid_before_end", cnt_valid, 0);
      if (o == 65) chk("valid_latency", cnt_valid, 1);
    end
    chk("en_idle", cnt_valid, 0);
    wait_drain("en");

    // Backpressure: three windows with ready low; third is dropped.
    do_reset(1'b0);
    cnt_ready = 1'b0;
    for (int k = 0; k < 3; k++) tog.push_back(4 + 4 * k);
    for (int k = 0; k < 5; k++) tog.push_back(68 + 4 * k);
    for (int k = 0; k < 7; k++) tog.push_back(132 + 4 * k);
    q.push_back(3); q.push_back(5);
    q4.push_back(3); q4.push_back(5); q4.push_back(7);
    @(negedge clk); enable = 1'b1;
    for (int o = 1; o <= 200; o++) begin
      @(negedge clk);
      if (tog.size() > 0 && tog[0] == o) begin
        tt_in = ~tt_in;
        void'(tog.pop_front());
      end
      if (o == 168) enable = 1'b0;
      if (o == 100) chk("bp_hold1", cnt_data, 3);
      if (o == 190) chk("bp_nodrop_yet", drop_err, 0);
    end
    chk("bp_drop", drop_err, 1);
    chk("bp_valid", cnt_valid, 1);
    chk("bp_hold", cnt_data, 3);
    chk("bp_drop4", drop_err4, 0);
    cnt_ready = 1'b1;
    wait_drain("bp");
    repeat (3) @(negedge clk);
    chk("bp_empty", cnt_valid, 0);

    // Reset mid-window after a gap violation.
    do_reset(1'b0);
    @(negedge clk); enable = 1'b1;
    for (int o = 1; o <= 30; o++) begin
      @(negedge clk);
      if (o == 4 || o == 5 || o == 8 || o == 12) tt_in = ~tt_in;
      if (o == 28) chk("mid_gap_set", gap_err, 1);
    end
    rst = 1'b1; enable = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", cnt_valid, 0);
    chk("mid_rst_data", cnt_data, 0);
    chk("mid_rst_gap", gap_err, 0);
    chk("mid_rst_sat", sat_err, 0);
    chk("mid_rst_drop", drop_err, 0);
    @(negedge clk); rst = 1'b0;
    repeat (100) @(negedge clk);
    chk("mid_no_result", cnt_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
